// File: rtl/pm_pkg.sv
// Shared constants, status encoding and helpers for the parking meter controller.
package pm_pkg;

  localparam int unsigned PM_W     = 16;
  localparam int unsigned PM_SUM_W = 17;

  localparam logic [PM_W-1:0] PM_MAX    = 16'd9999;
  localparam logic [PM_W-1:0] PM_LOW    = 16'd200;
  localparam logic [PM_W-1:0] PM_SET10  = 16'd10;
  localparam logic [PM_W-1:0] PM_SET205 = 16'd205;

  localparam logic [PM_W-1:0] PM_ADD0 = 16'd50;
  localparam logic [PM_W-1:0] PM_ADD1 = 16'd150;
  localparam logic [PM_W-1:0] PM_ADD2 = 16'd200;
  localparam logic [PM_W-1:0] PM_ADD3 = 16'd500;

  // Bit 0 is the is0 flag and bit 1 is the below200 flag.
  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_EXPIRED = 2'b01,
    ST_LOW     = 2'b10
  } pm_status_t;

  function automatic logic [PM_W-1:0] add_amount(input logic [1:0] idx);
    case (idx)
      2'd0:    add_amount = PM_ADD0;
      2'd1:    add_amount = PM_ADD1;
      2'd2:    add_amount = PM_ADD2;
      default: add_amount = PM_ADD3;
    endcase
  endfunction

  function automatic pm_status_t status_of(input logic [PM_W-1:0] v);
    if (v == '0)         status_of = ST_EXPIRED;
    else if (v < PM_LOW) status_of = ST_LOW;
    else                 status_of = ST_OK;
  endfunction

endpackage

// File: rtl/pm_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; one-cycle pulse out.
module pm_btn_edge
  import pm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse_c
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse_c = sync2 & ~prev;

endmodule

// File: rtl/parking_meter_controller.sv
// Parking meter remaining-time register, one-second countdown and status flags.
// Preset buttons are active only when PM_PRESET_EN is defined.
module parking_meter_controller
  import pm_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn_add,
  input  logic        btn_set10,
  input  logic        btn_set205,
  output logic [15:0] meter_data,
  output logic        below200,
  output logic        is0,
  output logic        second
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

  logic [3:0]          add_p_c;
  logic                set10_p_c;
  logic                set205_p_c;
  logic [CNT_W-1:0]    cnt;
  logic                tick_c;
  logic [PM_W-1:0]     dec_c;
  logic [PM_SUM_W-1:0] sum_c;
  logic [1:0]          add_idx_c;
  logic [PM_W-1:0]     value_n;
  pm_status_t          status_q;
  pm_status_t          status_n;

  for (genvar i = 0; i < 4; i++) begin : g_add
    pm_btn_edge u_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn     (btn_add[i]),
      .pulse_c (add_p_c[i])
    );
  end

`ifdef PM_PRESET_EN
  pm_btn_edge u_set10 (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn_set10),
    .pulse_c (set10_p_c)
  );

  pm_btn_edge u_set205 (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn_set205),
    .pulse_c (set205_p_c)
  );
`else
  logic unused_presets;
  assign unused_presets = btn_set10 ^ btn_set205;
  assign set10_p_c      = 1'b0;
  assign set205_p_c     = 1'b0;
`endif

  // Time value and status register; flags are bits of the status encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      second     <= 1'b0;
      meter_data <= '0;
      status_q   <= ST_EXPIRED;
    end else begin
      cnt        <= tick_c ? '0 : cnt + CNT_W'(1);
      second     <= (cnt < CNT_HALF);
      meter_data <= value_n;
      status_q   <= status_n;
    end
  end

  // Next value: preset beats add, add beats plain tick; tick decrements before add.
  always_comb begin
    tick_c    = (cnt == CNT_LAST);
    dec_c     = meter_data;
    sum_c     = '0;
    add_idx_c = 2'd0;
    value_n   = meter_data;

    if (tick_c && (meter_data != '0)) dec_c = meter_data - 16'd1;

    if (add_p_c[0])      add_idx_c = 2'd0;
    else if (add_p_c[1]) add_idx_c = 2'd1;
    else if (add_p_c[2]) add_idx_c = 2'd2;
    else                 add_idx_c = 2'd3;

    if (set205_p_c) begin
      value_n = PM_SET205;
    end else if (set10_p_c) begin
      value_n = PM_SET10;
    end else if (|add_p_c) begin
      sum_c   = PM_SUM_W'(dec_c) + PM_SUM_W'(add_amount(add_idx_c));
      value_n = (sum_c > PM_SUM_W'(PM_MAX)) ? PM_MAX : sum_c[PM_W-1:0];
    end else begin
      value_n = dec_c;
    end

    status_n = status_of(value_n);
  end

  assign is0      = status_q[0];
  assign below200 = status_q[1];

endmodule

// File: tb/tb_parking_meter_controller.sv
// Directed bench for parking_meter_controller with TICK_DIV=8.
module tb_parking_meter_controller;

  logic        clk;
  logic        rst_n;
  logic [3:0]  btn_add;
  logic        btn_set10;
  logic        btn_set205;
  logic [15:0] meter_data;
  logic        below200;
  logic        is0;
  logic        second;

  int n_cmp;
  int n_err;
  int edge_cnt;

  parking_meter_controller #(.TICK_DIV(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_add    (btn_add),
    .btn_set10  (btn_set10),
    .btn_set205 (btn_set205),
    .meter_data (meter_data),
    .below200   (below200),
    .is0        (is0),
    .second     (second)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since the last reset release; edge n is the n-th clk edge out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Return at the falling edge that follows edge e.
  task automatic run_to(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Hold the given buttons high so that edge e is the first edge to sample them.
  task automatic press(input logic [3:0] a, input logic s10, input logic s205, input int e);
    run_to(e - 1);
    btn_add    = a;
    btn_set10  = s10;
    btn_set205 = s205;
    run_to(e);
    btn_add    = 4'b0000;
    btn_set10  = 1'b0;
    btn_set205 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    btn_add    = 4'b0000;
    btn_set10  = 1'b0;
    btn_set205 = 1'b0;
    do_reset();

    // Reset state, first coin, second phase, threshold and dual add
    run_to(0);
    chk("rst_data", int'(meter_data), 0);
    chk("rst_is0", int'(is0), 1);
    chk("rst_below200", int'(below200), 0);
    chk("rst_second", int'(second), 0);
    press(4'b0001, 1'b0, 1'b0, 1);
    chk("second_e1", int'(second), 1);
    run_to(2);
    chk("latency_e2", int'(meter_data), 0);
    chk("latency_is0_e2", int'(is0), 1);
    press(4'b0010, 1'b0, 1'b0, 3);
    chk("coin50_data", int'(meter_data), 50);
    chk("coin50_is0", int'(is0), 0);
    chk("coin50_below200", int'(below200), 1);
    run_to(4);
    chk("second_e4", int'(second), 1);
    run_to(5);
    chk("second_e5", int'(second), 0);
    chk("add150_data", int'(meter_data), 200);
    run_to(7);
    chk("pre_tick_data", int'(meter_data), 200);
    chk("pre_tick_below200", int'(below200), 0);
    run_to(8);
    chk("tick_200_data", int'(meter_data), 199);
    chk("tick_200_below200", int'(below200), 1);
    chk("second_e8", int'(second), 0);
    press(4'b1010, 1'b0, 1'b0, 9);
    chk("second_e9", int'(second), 1);
    run_to(10);
    chk("dual_add_latency", int'(meter_data), 199);
    run_to(11);
    chk("dual_add_lowest", int'(meter_data), 349);
    chk("dual_add_below200", int'(below200), 0);
    run_to(16);
    chk("tick_e16", int'(meter_data), 348);
    run_to(18);
    chk("second_e18", int'(second), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", int'(meter_data), 0);
    chk("async_rst_second", int'(second), 0);
    chk("async_rst_is0", int'(is0), 1);

    // Add on a tick edge, presets, countdown to expiry
    do_reset();
    press(4'b0001, 1'b0, 1'b0, 1);
    press(4'b0010, 1'b0, 1'b0, 3);
    press(4'b0010, 1'b0, 1'b0, 6);
    run_to(7);
    chk("b_pre_tick", int'(meter_data), 200);
    run_to(8);
    chk("add_with_tick", int'(meter_data), 349);
    press(4'b0000, 1'b1, 1'b1, 9);
    run_to(10);
    chk("preset_latency", int'(meter_data), 349);
    run_to(11);
`ifdef PM_PRESET_EN
    chk("both_presets", int'(meter_data), 205);
`else
    chk("presets_ignored", int'(meter_data), 349);
`endif
    press(4'b0000, 1'b1, 1'b0, 13);
    run_to(15);
`ifdef PM_PRESET_EN
    chk("preset10", int'(meter_data), 10);
    run_to(16);
    chk("preset_keeps_tick", int'(meter_data), 9);
    run_to(80);
    chk("count_e80", int'(meter_data), 1);
    chk("count_e80_below200", int'(below200), 1);
    run_to(88);
    chk("expired_data", int'(meter_data), 0);
    chk("expired_is0", int'(is0), 1);
    chk("expired_below200", int'(below200), 0);
    run_to(96);
    chk("tick_at_zero", int'(meter_data), 0);
`else
    chk("set10_ignored", int'(meter_data), 349);
    run_to(16);
    chk("tick_no_preset", int'(meter_data), 348);
`endif

    // Saturation at 9999
    do_reset();
    for (int i = 0; i < 19; i++) press(4'b1000, 1'b0, 1'b0, 2 * i + 1);
    press(4'b1000, 1'b0, 1'b0, 39);
    chk("sat_ramp_e39", int'(meter_data), 9496);
    press(4'b1000, 1'b0, 1'b0, 41);
    chk("sat_ramp_e41", int'(meter_data), 9995);
    press(4'b0001, 1'b0, 1'b0, 43);
    chk("sat_clamp500", int'(meter_data), 9999);
    run_to(45);
    chk("sat_clamp50", int'(meter_data), 9999);
    chk("sat_is0", int'(is0), 0);
    chk("sat_below200", int'(below200), 0);
    run_to(48);
    chk("sat_tick", int'(meter_data), 9998);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parking_meter_controller.md
# parking_meter_controller

Time-keeping controller for the parking meter. It owns the remaining-time register and accepts coin and preset button events. It counts the time down once per second and drives the status flags and blink phase that the display controller consumes. Outputs connect directly to the display controller's `meter_data`, `below200`, `is0` and `second` inputs.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clk cycles per one-second tick. Must be even and ≥ 4.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_add`  in  4  coin buttons, asynchronous and debounced upstream. Bit values: [0] +50, [1] +150, [2] +200, [3] +500 seconds.
- `btn_set10`  in  1  preset button: set time to 10 s.
- `btn_set205`  in  1  preset button: set time to 205 s.
- `meter_data`  out  16  remaining seconds, binary, 0..9999.
- `below200`  out  1  high when 1 ≤ `meter_data` ≤ 199.
- `is0`  out  1  high when `meter_data` == 0.
- `second`  out  1  blink phase: high during the first half of each tick period.

## Operation
- **Button input path:** each button goes through a 2-flop synchronizer, then a rising-edge detector. Only the rising edge acts; holding a button adds nothing further.
- **Tick counter:** `cnt` runs 0..TICK_DIV-1 and wraps. A tick occurs in the cycle where `cnt` == TICK_DIV-1. `second` is registered as (`cnt` < TICK_DIV/2).
- **Per-cycle priority for the next value:**
  - A preset edge wins. If both presets fire in the same cycle, `btn_set205` wins.
  - Otherwise an add edge applies. If several add edges fire together, only the lowest index is taken; the others are dropped.
  - A tick decrements the value by 1 when the value is > 0. A tick at 0 has no effect.
- **Tick in the same cycle as an event:**
  - With an add: decrement first, then add, then saturate.
  - With a preset: the value becomes exactly the preset, with no decrement.
- **Saturation:** additions use 17-bit intermediates and clamp to 9999. There is never wrap-around.
- **Status state (registered, computed from the next value):**
  - EXPIRED: value 0, `is0`=1.
  - LOW: value 1..199, `below200`=1.
  - OK: value ≥ 200, both flags 0.
  - All transitions are legal in a single cycle, e.g. EXPIRED→OK via +500, or OK→LOW on a tick from 200 to 199.
- Presets do not restart the tick counter. Nothing other than reset restarts it.

## Timing
- **Reset values:** `meter_data`=0, `is0`=1, `below200`=0, `second`=0, `cnt`=0, all synchronizer and edge flops 0.
- After reset deassertion, `second` goes high on the first clk edge.
- **Button latency:** let edge k be the first clk edge that samples a button high. `meter_data` and the flags update at edge k+2.
- **Ticks:** a tick lands every TICK_DIV cycles. The first tick after reset is at cycle TICK_DIV. `meter_data` and the flags change on the same edge as each other.
- Reset asserted mid-count clears all state immediately. Button edges in flight are lost.

## Configuration
- `PM_PRESET_EN` defined: preset buttons work as described.
- `PM_PRESET_EN` undefined:
  - `btn_set10` and `btn_set205` are ignored, and their synchronizers are not built.
  - Ports remain present.
  - Only add edges and ticks change the value.

## Structure
- **Package `pm_pkg`** holds:
  - Add amounts: 50, 150, 200, 500.
  - Preset values: 10, 205.
  - `PM_MAX` = 9999 and `PM_LOW` = 200.
  - The status enum EXPIRED / LOW / OK.
- **Sub-module `pm_btn_edge`** contains the 2-flop synchronizer plus the rising-edge register, with a 1-cycle pulse output. It is instantiated once per button.

## Test plan
(All scenarios use TICK_DIV=8.)
- **Reset and first coin:** release reset, pulse `btn_add[0]` → `meter_data`=50 at the 3rd edge; `is0` 1→0; `below200`=1.
- **Saturation:** from 9800, press +500 → 9999. A further +50 stays at 9999.
- **Countdown to expiry:** preset 10 (with `PM_PRESET_EN`), run 10 ticks → value 0, `is0`=1, `below200`=0. An 11th tick leaves 0. `second` has period 8 and is high for 4 cycles.
- **Simultaneous events:**
  - Value 200, +150 edge in a tick cycle → 349.
  - `btn_add[1]` and `btn_add[3]` in the same cycle → only +150 applied.
  - Both presets together → 205.
- **Threshold crossing:** value 200 plus one tick → 199, `below200` rises on the same edge as `meter_data`.
- **Macro off / async reset:**
  - Without `PM_PRESET_EN`, presses of `btn_set205` leave the value unchanged.
  - Asserting `rst_n` low mid-tick forces `meter_data`=0 and `second`=0 without waiting for a clk edge.
